// File: rtl/clk_freq_meter_pkg.sv
// Shared constants for the clock frequency meter: FSM encoding and the default
// expected period for the 50 MHz system clock / 1 MHz divided clock pair.
package clk_freq_meter_pkg;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_MEAS = 1'b1
  } meter_state_e;

  localparam int unsigned DefExpPeriod = 50;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer plus an edge flop; emits a one-cycle pulse on each
// synchronized rising edge of din.
module sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic sync1_q, sync2_q, sync3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Measures the period of an asynchronous slow clock in system clock cycles,
// tracks lock against an expected period and flags out-of-range or lost clock.
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int unsigned EXP_PERIOD = DefExpPeriod,
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned TIMEOUT    = 200,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             fault
);

  localparam int unsigned      GoodW      = $clog2(LOCK_CNT + 1);
  // Lower bound clamps at zero so a tolerance wider than the period cannot wrap.
  localparam int unsigned      LoInt      = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
  localparam logic [CNT_W:0]   RangeLo    = (CNT_W + 1)'(LoInt);
  localparam logic [CNT_W:0]   RangeHi    = (CNT_W + 1)'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] CntTimeout = CNT_W'(TIMEOUT - 1);
  localparam logic [GoodW-1:0] GoodMax    = GoodW'(LOCK_CNT);

  meter_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             fault_q, fault_d;
  logic [GoodW-1:0] good_q, good_d, good_inc;
  logic             rise, cnt_max, in_range;
  logic [CNT_W:0]   meas;

  sync_rise u_sync_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (clk_in),
    .rise  (rise)
  );

  always_comb begin
    cnt_max  = (cnt_q == '1);
    meas     = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    in_range = (meas >= RangeLo) && (meas <= RangeHi);
    good_inc = (good_q == GoodMax) ? good_q : good_q + GoodW'(1);

    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    fault_d  = fault_q;
    good_d   = good_q;

    case (state_q)
      S_WAIT: begin
        cnt_d = '0;
        if (rise) begin
          state_d = S_MEAS;
        end
      end
      S_MEAS: begin
        // A rise on the timeout cycle takes priority and is measured normally.
        if (rise) begin
          cnt_d    = '0;
          valid_d  = 1'b1;
          period_d = cnt_max ? cnt_q : meas[CNT_W-1:0];
          if (in_range) begin
            good_d   = good_inc;
            fault_d  = 1'b0;
            locked_d = (good_inc == GoodMax);
          end else begin
            good_d   = '0;
            locked_d = 1'b0;
            fault_d  = 1'b1;
          end
        end else if (cnt_q == CntTimeout) begin
          state_d  = S_WAIT;
          cnt_d    = '0;
          good_d   = '0;
          locked_d = 1'b0;
          fault_d  = 1'b1;
        end else if (!cnt_max) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_WAIT;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
      good_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
      good_q   <= good_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign fault        = fault_q;

endmodule
